// File: rtl/reg_pipeline.sv
// Multi-stage valid/ready register pipeline with bubble collapsing and synchronous flush.
// Retiming delay line: DEPTH stages of WIDTH-bit data, each carrying its own valid bit.
`timescale 1ns/1ps
module reg_pipeline #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             accept;

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + OCC_W'(vec[i]);
        end
        return cnt;
    endfunction

    // A stage may advance when the output drains or any stage at or downstream of it is empty;
    // unrolling the chain this way avoids a combinational loop through adv itself.
    always_comb begin
        logic hole;
        hole = 1'b0;
        adv  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            hole   = hole | ~v_q[k];
            adv[k] = out_ready | hole;
        end
    end

    assign in_ready = rst_n & ~flush & adv[0];
    assign accept   = in_valid & in_ready;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
        end else begin
            if (adv[0]) begin
                v_d[0] = accept;
                if (accept) begin
                    d_d[0] = in_data;
                end
            end
            // Data only moves with a valid word so idle stages keep their last contents.
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end
                end
            end
        end
        occ_d = popcount(v_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= RESET_VAL;
            end
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;
endmodule

// File: tb/tb_reg_pipeline.sv
// Bench for reg_pipeline: a DEPTH=4/WIDTH=8 and a DEPTH=1/WIDTH=6 instance checked every
// cycle against a word-list reference model, plus directed latency/stream/stall/flush/reset cases.
`timescale 1ns/1ps
module tb_reg_pipeline;
    localparam int DA = 4;
    localparam int WA = 8;
    localparam int DB = 1;
    localparam int WB = 6;
    localparam logic [WA-1:0] RVA = 8'h3C;
    localparam logic [WB-1:0] RVB = 6'h2A;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_flush = 1'b0, a_vin = 1'b0, a_rdy = 1'b0;
    logic [WA-1:0] a_din = '0;
    logic          a_in_ready, a_out_valid;
    logic [WA-1:0] a_out_data;
    logic [2:0]    a_occ;
    logic          b_flush = 1'b0, b_vin = 1'b0, b_rdy = 1'b0;
    logic [WB-1:0] b_din = '0;
    logic          b_in_ready, b_out_valid;
    logic [WB-1:0] b_out_data;
    logic [0:0]    b_occ;

    reg_pipeline #(.WIDTH(WA), .DEPTH(DA), .RESET_VAL(RVA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_vin), .in_ready(a_in_ready),
        .in_data(a_din), .out_valid(a_out_valid), .out_ready(a_rdy), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    reg_pipeline #(.WIDTH(WB), .DEPTH(DB), .RESET_VAL(RVB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_vin), .in_ready(b_in_ready),
        .in_data(b_din), .out_valid(b_out_valid), .out_ready(b_rdy), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, an ordered list of in-flight words (oldest first) with
    // their stage positions; last[] is whatever word most recently reached the last stage.
    int m_cnt   [2];
    int m_pos   [2][8];
    int m_dat   [2][8];
    int m_last  [2];
    int m_depth [2];
    bit a_acc, b_acc;

    task automatic m_reset();
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_last[0] = int'(RVA); m_last[1] = int'(RVB);
        m_depth[0] = DA; m_depth[1] = DB;
    endtask

    function automatic bit m_ready(input int w, input bit rdy, input bit fl);
        return !fl && ((m_cnt[w] < m_depth[w]) || rdy);
    endfunction

    function automatic bit m_out_valid(input int w);
        return (m_cnt[w] > 0) && (m_pos[w][0] == m_depth[w] - 1);
    endfunction

    task automatic m_step(input int w, input bit rdy, input bit vin, input int din,
                          input bit fl, output bit acc);
        int lim, np, d;
        d   = m_depth[w];
        acc = vin && m_ready(w, rdy, fl);
        if (fl) begin
            m_cnt[w] = 0;
            return;
        end
        if (m_out_valid(w) && rdy) begin
            for (int i = 0; i < m_cnt[w] - 1; i++) begin
                m_pos[w][i] = m_pos[w][i+1];
                m_dat[w][i] = m_dat[w][i+1];
            end
            m_cnt[w]--;
        end
        lim = d - 1;
        for (int i = 0; i < m_cnt[w]; i++) begin
            np = (m_pos[w][i] + 1 < lim) ? m_pos[w][i] + 1 : lim;
            m_pos[w][i] = np;
            if (np == d - 1) m_last[w] = m_dat[w][i];
            lim = np - 1;
        end
        if (acc) begin
            m_pos[w][m_cnt[w]] = 0;
            m_dat[w][m_cnt[w]] = din;
            m_cnt[w]++;
            if (d == 1) m_last[w] = din;
        end
    endtask

    // One clock cycle: caller is between edges with inputs already set.
    task automatic tick();
        #1;
        check_eq("a_in_ready", 32'(a_in_ready), 32'(m_ready(0, a_rdy, a_flush)));
        check_eq("b_in_ready", 32'(b_in_ready), 32'(m_ready(1, b_rdy, b_flush)));
        m_step(0, a_rdy, a_vin, int'(a_din), a_flush, a_acc);
        m_step(1, b_rdy, b_vin, int'(b_din), b_flush, b_acc);
        @(posedge clk);
        #1;
        check_eq("a_out_valid", 32'(a_out_valid), 32'(m_out_valid(0)));
        check_eq("a_out_data", 32'(a_out_data), m_last[0]);
        check_eq("a_occupancy", 32'(a_occ), m_cnt[0]);
        check_eq("b_out_valid", 32'(b_out_valid), 32'(m_out_valid(1)));
        check_eq("b_out_data", 32'(b_out_data), m_last[1]);
        check_eq("b_occupancy", 32'(b_occ), m_cnt[1]);
    endtask

    task automatic idle_all();
        a_vin = 1'b0; a_flush = 1'b0;
        b_vin = 1'b0; b_flush = 1'b0;
    endtask

    task automatic drain();
        idle_all();
        a_rdy = 1'b1; b_rdy = 1'b1;
        repeat (DA + 2) tick();
    endtask

    task automatic measure_latency(input int w, input int val);
        int n;
        bit seen;
        if (w == 0) begin a_rdy = 1'b1; a_vin = 1'b1; a_din = WA'(val); end
        else        begin b_rdy = 1'b1; b_vin = 1'b1; b_din = WB'(val); end
        tick();
        check_eq("lat_accept", 32'(w == 0 ? a_acc : b_acc), 32'd1);
        idle_all();
        n = 1;
        seen = (w == 0) ? a_out_valid : b_out_valid;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = (w == 0) ? a_out_valid : b_out_valid;
        end
        check_eq("lat_cycles", n, (w == 0) ? DA : DB);
        check_eq("lat_data", (w == 0) ? 32'(a_out_data) : 32'(b_out_data), val);
        tick();
        check_eq("lat_one_cycle", (w == 0) ? 32'(a_out_valid) : 32'(b_out_valid), 32'd0);
    endtask

    int bp_dat [6] = '{8'h11, 0, 8'h22, 0, 8'h33, 8'h44};
    bit bp_vld [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int bp_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int got [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(a_in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
        check_eq("rst_out_data", 32'(a_out_data), 32'(RVA));
        check_eq("rst_occupancy", 32'(a_occ), 32'd0);
        check_eq("rst_b_out_data", 32'(b_out_data), 32'(RVB));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 32'(a_in_ready), 32'd1);
        check_eq("post_rst_b_in_ready", 32'(b_in_ready), 32'd1);

        measure_latency(0, 8'hA5);
        measure_latency(1, 6'h25);

        // Streaming 01..10 back-to-back
        a_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_vin = 1'b1; a_din = WA'(i);
            tick();
            check_eq("stream_accept", 32'(a_acc), 32'd1);
            if (a_out_valid) got.push_back(int'(a_out_data));
        end
        a_vin = 1'b0;
        repeat (DA + 1) begin
            tick();
            if (a_out_valid) got.push_back(int'(a_out_data));
        end
        check_eq("stream_count", got.size(), 16);
        for (int i = 0; i < got.size() && i < 16; i++) check_eq("stream_order", got[i], i + 1);

        // Backpressure with gaps collapsing into a full pipe
        a_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_vin = bp_vld[i]; a_din = WA'(bp_dat[i]);
            tick();
        end
        a_vin = 1'b0;
        #1;
        check_eq("bp_occupancy", 32'(a_occ), 32'd4);
        check_eq("bp_in_ready", 32'(a_in_ready), 32'd0);
        a_vin = 1'b1; a_din = 8'h55;
        tick();
        check_eq("bp_fifth_rejected", 32'(a_acc), 32'd0);
        a_vin = 1'b0;
        repeat (2) begin
            tick();
            check_eq("bp_stall_data", 32'(a_out_data), 32'h11);
            check_eq("bp_stall_valid", 32'(a_out_valid), 32'd1);
        end
        a_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_drain_valid", 32'(a_out_valid), 32'd1);
            check_eq("bp_drain_data", 32'(a_out_data), bp_exp[i]);
            tick();
        end
        check_eq("bp_drained", 32'(a_out_valid), 32'd0);

        // Flush with three words in flight and a word offered at the same edge
        a_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_vin = 1'b1; a_din = WA'(8'h66 + 8'h11 * i);
            tick();
        end
        check_eq("fl_occupancy_before", 32'(a_occ), 32'd3);
        a_flush = 1'b1; a_vin = 1'b1; a_din = 8'h99;
        tick();
        check_eq("fl_not_accepted", 32'(a_acc), 32'd0);
        check_eq("fl_occupancy", 32'(a_occ), 32'd0);
        check_eq("fl_out_valid", 32'(a_out_valid), 32'd0);
        idle_all();
        measure_latency(0, 8'h5C);

        // Randomised traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_rdy   = 1'($urandom_range(0, 1));
            a_vin   = ($urandom_range(0, 9) < 6);
            a_din   = WA'($urandom);
            a_flush = ($urandom_range(0, 31) == 0);
            b_rdy   = 1'($urandom_range(0, 1));
            b_vin   = ($urandom_range(0, 9) < 6);
            b_din   = WB'($urandom);
            b_flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        drain();

        // Asynchronous reset while the pipe is full
        a_rdy = 1'b0; b_rdy = 1'b0;
        for (int i = 0; i < DA; i++) begin
            a_vin = 1'b1; a_din = WA'(8'hE0 + i);
            b_vin = (i == 0); b_din = 6'h17;
            tick();
        end
        idle_all();
        check_eq("ar_full", 32'(a_occ), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_out_valid", 32'(a_out_valid), 32'd0);
        check_eq("ar_out_data", 32'(a_out_data), 32'(RVA));
        check_eq("ar_occupancy", 32'(a_occ), 32'd0);
        check_eq("ar_in_ready", 32'(a_in_ready), 32'd0);
        check_eq("ar_b_out_valid", 32'(b_out_valid), 32'd0);
        check_eq("ar_b_out_data", 32'(b_out_data), 32'(RVB));
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        measure_latency(0, 8'hC3);
        measure_latency(1, 6'h3E);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
